// File: rtl/jk_bank_pkg.sv
// Shared FSM state and JK cell excitation codes for the JK bank driver.
// Codes are {J,K} as seen by the external bank cells.
package jk_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b10;
  localparam logic [1:0] JK_SET  = 2'b01;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_excite_bit.sv
// One-cell excitation: maps (current, target) to {J,K}; purely combinational, no handshake.
// Build option JK_BANK_DRIVER_TOGGLE_EN drives every changing cell with the toggle code.
module jk_excite_bit
  import jk_bank_pkg::*;
(
  input  logic       e_i,
  input  logic       t_i,
  output logic [1:0] jk_o
);

  always_comb begin
    jk_o = JK_HOLD;
    if (e_i != t_i) begin
`ifdef JK_BANK_DRIVER_TOGGLE_EN
      jk_o = JK_TGL;
`else
      jk_o = t_i ? JK_SET : JK_CLR;
`endif
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Loads target words into an external JK bank: handshake -> DRIVE -> CHECK, done 3 edges later;
// tgt_ready is low while a word is in flight. Option JK_BANK_DRIVER_TOGGLE_EN selects toggle excitation.
module jk_bank_driver
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] exp_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] tgt_q,   tgt_d;
  logic [WIDTH-1:0] j_q,     j_d;
  logic [WIDTH-1:0] k_q,     k_d;
  logic [WIDTH-1:0] exp_q_q, exp_q_d;
  logic             err_q,   err_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             done_q,  done_d;

  logic [WIDTH-1:0] exc_j, exc_k;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [1:0] jk_bit;
    jk_excite_bit u_bit (
      .e_i  (exp_q_q[i]),
      .t_i  (tgt_data[i]),
      .jk_o (jk_bit)
    );
    assign exc_j[i] = jk_bit[1];
    assign exc_k[i] = jk_bit[0];
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    tgt_d   = tgt_q;
    j_d     = '0;
    k_d     = '0;
    exp_q_d = exp_q_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (tgt_valid && ready_q) begin
          tgt_d   = tgt_data;
          j_d     = exc_j;
          k_d     = exc_k;
          ready_d = 1'b0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        ready_d = 1'b1;
        done_d  = 1'b1;
        if (q_fb == tgt_q) begin
          exp_q_d = tgt_q;
        end else begin
          // Resync to what the bank really holds; a mismatch overrides a same-edge clear.
          exp_q_d = q_fb;
          err_d   = 1'b1;
          if (err_clr) begin
            cnt_d = CNT_ONE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      exp_q_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      tgt_q   <= tgt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      exp_q_q <= exp_q_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign tgt_ready = ready_q;
  assign jk_j      = j_q;
  assign jk_k      = k_q;
  assign exp_q     = exp_q_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: JK bank environment with injectable cell faults and a word-level reference.
// Follows JK_BANK_DRIVER_TOGGLE_EN so the expected excitation matches the build under test.
module tb_jk_bank_driver;

  localparam int W    = 8;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef JK_BANK_DRIVER_TOGGLE_EN
  localparam bit TGL = 1'b1;
`else
  localparam bit TGL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          tgt_valid;
  logic          tgt_ready;
  logic [W-1:0]  tgt_data;
  logic [W-1:0]  jk_j, jk_k;
  logic [W-1:0]  q_fb;
  logic [W-1:0]  exp_q;
  logic          busy, done, err;
  logic [CW-1:0] err_cnt;
  logic          err_clr;

  logic [W-1:0]  bank_q;
  logic [W-1:0]  flip_mask;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] ref_exp;
  logic         ref_err;
  int           ref_cnt;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .jk_j      (jk_j),
    .jk_k      (jk_k),
    .q_fb      (q_fb),
    .exp_q     (exp_q),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  // External bank: {J,K} 00 hold, 10 clear, 01 set, 11 toggle; flip_mask models faulty cells.
  function automatic logic [W-1:0] bank_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                              input logic [W-1:0] k);
    logic [W-1:0] n;
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b00:   n[i] = q[i];
        2'b10:   n[i] = 1'b0;
        2'b01:   n[i] = 1'b1;
        default: n[i] = ~q[i];
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) bank_q <= '0;
    else     bank_q <= bank_next(bank_q, jk_j, jk_k) ^ flip_mask;
  end
  assign q_fb = bank_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done should be high.
  task automatic xfer(input logic [W-1:0] t, input logic [W-1:0] flip, input bit clr);
    logic [W-1:0] diff, ej, ek;
    diff = ref_exp ^ t;
    if (TGL) begin
      ej = diff;
      ek = diff;
    end else begin
      ej = ref_exp & ~t;
      ek = ~ref_exp & t;
    end
    tgt_valid = 1'b1;
    tgt_data  = t;
    chk("idle_ready", tgt_ready, 1);
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 1'($urandom_range(0, 1));
    tgt_data  = W'($urandom);
    chk("drive_j", jk_j, ej);
    chk("drive_k", jk_k, ek);
    chk("drive_busy", busy, 1);
    chk("drive_ready", tgt_ready, 0);
    chk("drive_done", done, 0);
    flip_mask = flip;
    @(posedge clk);
    @(negedge clk);
    flip_mask = '0;
    err_clr   = clr;
    tgt_valid = 1'($urandom_range(0, 1));
    chk("check_jk", {jk_j, jk_k}, 0);
    chk("check_busy", busy, 1);
    ref_exp = t ^ flip;
    if (clr) begin
      ref_err = 1'b0;
      ref_cnt = 0;
    end
    if (flip != '0) begin
      ref_err = 1'b1;
      ref_cnt = clr ? 1 : ((ref_cnt < CMAX) ? ref_cnt + 1 : CMAX);
    end
    @(posedge clk);
    @(negedge clk);
    err_clr   = 1'b0;
    tgt_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_ready", tgt_ready, 1);
    chk("done_busy", busy, 0);
    chk("exp_q", exp_q, ref_exp);
    chk("err", err, ref_err);
    chk("err_cnt", err_cnt, ref_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    err_clr   = 1'b0;
    flip_mask = '0;
    ref_exp   = '0;
    ref_err   = 1'b0;
    ref_cnt   = 0;

    repeat (3) @(negedge clk);
    chk("rst_ready", tgt_ready, 0);
    chk("rst_outs", {jk_j, jk_k, exp_q, busy, done, err, err_cnt}, 0);
    rst = 1'b0;
    chk("rel_ready", tgt_ready, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", tgt_ready, 1);
      chk("idle_jk", {jk_j, jk_k}, 0);
      chk("idle_status", {busy, done, err, err_cnt, exp_q}, 0);
    end

    xfer(8'hA5, 8'h00, 1'b0);
    xfer(8'h3C, 8'h00, 1'b0);
    xfer(8'h3C, 8'h01, 1'b0);
    xfer(8'h3C, 8'h00, 1'b0);
    xfer(8'h55, 8'h10, 1'b1);

    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    ref_err = 1'b0;
    ref_cnt = 0;
    chk("clr_idle_err", err, 0);
    chk("clr_idle_cnt", err_cnt, 0);
    chk("clr_idle_done", done, 0);

    for (int n = 0; n < 300; n++) begin
      xfer(W'($urandom), W'($urandom_range(1, 255)), 1'b0);
    end
    chk("sat_cnt", err_cnt, CMAX);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] f;
      f = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 255)) : '0;
      xfer(W'($urandom), f, ($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap_done", done, 0);
      end
    end

    // Force a nonzero count so the asynchronous clear is observable.
    xfer(8'h0F, 8'h80, 1'b0);
    tgt_valid = 1'b1;
    tgt_data  = W'($urandom);
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_jk", {jk_j, jk_k}, 0);
    chk("arst_status", {busy, done, err, err_cnt, tgt_ready}, 0);
    chk("arst_exp", exp_q, 0);
    ref_exp = '0;
    ref_err = 1'b0;
    ref_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("arst_rel_ready", tgt_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_done", done, 0);
      chk("arst_ready", tgt_ready, 1);
    end
    xfer(8'hFF, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
